// File: rtl/adaptive_thresh_3x3.sv
// ---------------------------------------------------------------------------
// adaptive_thresh_3x3
//   Local-mean adaptive binarisation of a 3x3 pixel window. For every valid
//   window the exact 9-pixel mean is formed, a fixed OFFSET is subtracted
//   (saturating at zero), and the centre pixel is compared against it:
//   centre > threshold gives 8'd255, otherwise 8'd0. Four register stages,
//   no stall, one window per clock. The output raster position is tracked
//   so the last pixel of a frame raises frame_done, and the frame border
//   can optionally be forced to background.
//
// Ports
//   clk                 in   pixel clock
//   rst_n               in   asynchronous active-low reset
//   matrix_vld          in   window valid (one window per high cycle)
//   matrix_11..33 [7:0] in   window pixels, row-major, matrix_22 is centre
//   dout_vld            out  binary pixel valid, 4 clocks after matrix_vld
//   dout [7:0]          out  8'd255 foreground / 8'd0 background
//   frame_done          out  1-cycle pulse with pixel (V_DISP-1, H_DISP-1)
// ---------------------------------------------------------------------------
module adaptive_thresh_3x3 #(
  parameter logic [11:0] H_DISP      = 12'd640,
  parameter logic [11:0] V_DISP      = 12'd480,
  parameter logic [7:0]  OFFSET      = 8'd5,
  parameter logic        BORDER_ZERO = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       matrix_vld,
  input  logic [7:0] matrix_11,
  input  logic [7:0] matrix_12,
  input  logic [7:0] matrix_13,
  input  logic [7:0] matrix_21,
  input  logic [7:0] matrix_22,
  input  logic [7:0] matrix_23,
  input  logic [7:0] matrix_31,
  input  logic [7:0] matrix_32,
  input  logic [7:0] matrix_33,
  output logic       dout_vld,
  output logic [7:0] dout,
  output logic       frame_done
);

  // 65536/9 rounded up; (sum*7282)>>16 equals floor(sum/9) for sum <= 2295
  localparam logic [24:0] RECIP9 = 25'd7282;

  // Stage 1: row sums and centre
  logic       vld1_q, vld1_d;
  logic [9:0] r1_q, r1_d;
  logic [9:0] r2_q, r2_d;
  logic [9:0] r3_q, r3_d;
  logic [7:0] c1_q, c1_d;

  // Stage 2: full window sum
  logic        vld2_q, vld2_d;
  logic [11:0] sum_q, sum_d;
  logic [7:0]  c2_q, c2_d;

  // Stage 3: threshold
  logic        vld3_q, vld3_d;
  logic [7:0]  thr_q, thr_d;
  logic [7:0]  c3_q, c3_d;
  logic [24:0] prod_s;
  logic [7:0]  mean_s;

  // Raster position of the pixel currently in stage 3
  logic [11:0] cnt_col_q, cnt_col_d;
  logic [11:0] cnt_row_q, cnt_row_d;
  logic        col_last_s;
  logic        row_last_s;
  logic        border_s;

  // Stage 4: registered outputs
  logic       dout_vld_q, dout_vld_d;
  logic [7:0] dout_q, dout_d;
  logic       frame_done_q, frame_done_d;

  // Stage 1 next-state: widen each pixel to 10 bits and add along rows
  always_comb begin
    vld1_d = matrix_vld;
    r1_d   = {2'b00, matrix_11} + {2'b00, matrix_12} + {2'b00, matrix_13};
    r2_d   = {2'b00, matrix_21} + {2'b00, matrix_22} + {2'b00, matrix_23};
    r3_d   = {2'b00, matrix_31} + {2'b00, matrix_32} + {2'b00, matrix_33};
    c1_d   = matrix_22;
  end

  // Stage 2 next-state: total of the three row sums (max 2295 fits 12 bits)
  always_comb begin
    vld2_d = vld1_q;
    sum_d  = {2'b00, r1_q} + {2'b00, r2_q} + {2'b00, r3_q};
    c2_d   = c1_q;
  end

  // Stage 3 next-state: exact mean by reciprocal multiply, then saturating bias
  always_comb begin
    prod_s = {13'd0, sum_q} * RECIP9;
    mean_s = 8'(prod_s >> 16);
    vld3_d = vld2_q;
    c3_d   = c2_q;
    if (mean_s > OFFSET) begin
      thr_d = mean_s - OFFSET;
    end else begin
      thr_d = 8'd0;
    end
  end

  // Raster counters: step once per window leaving stage 3, row-major wrap
  always_comb begin
    col_last_s = (cnt_col_q == (H_DISP - 12'd1));
    row_last_s = (cnt_row_q == (V_DISP - 12'd1));
    border_s   = (cnt_col_q == 12'd0) || col_last_s ||
                 (cnt_row_q == 12'd0) || row_last_s;
    cnt_col_d  = cnt_col_q;
    cnt_row_d  = cnt_row_q;
    if (vld3_q) begin
      if (col_last_s) begin
        cnt_col_d = 12'd0;
        if (row_last_s) begin
          cnt_row_d = 12'd0;
        end else begin
          cnt_row_d = cnt_row_q + 12'd1;
        end
      end else begin
        cnt_col_d = cnt_col_q + 12'd1;
        cnt_row_d = cnt_row_q;
      end
    end else begin
      cnt_col_d = cnt_col_q;
      cnt_row_d = cnt_row_q;
    end
  end

  // Stage 4 next-state: strict compare, optional border mask, frame end flag
  always_comb begin
    dout_vld_d   = vld3_q;
    frame_done_d = vld3_q && col_last_s && row_last_s;
    if (!vld3_q) begin
      // idle slots present background so stale data never leaks out
      dout_d = 8'd0;
    end else if ((BORDER_ZERO == 1'b1) && border_s) begin
      dout_d = 8'd0;
    end else if (c3_q > thr_q) begin
      dout_d = 8'd255;
    end else begin
      dout_d = 8'd0;
    end
  end

  // All pipeline, counter and output registers; reset discards in-flight data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld1_q       <= 1'b0;
      r1_q         <= 10'd0;
      r2_q         <= 10'd0;
      r3_q         <= 10'd0;
      c1_q         <= 8'd0;
      vld2_q       <= 1'b0;
      sum_q        <= 12'd0;
      c2_q         <= 8'd0;
      vld3_q       <= 1'b0;
      thr_q        <= 8'd0;
      c3_q         <= 8'd0;
      cnt_col_q    <= 12'd0;
      cnt_row_q    <= 12'd0;
      dout_vld_q   <= 1'b0;
      dout_q       <= 8'd0;
      frame_done_q <= 1'b0;
    end else begin
      vld1_q       <= vld1_d;
      r1_q         <= r1_d;
      r2_q         <= r2_d;
      r3_q         <= r3_d;
      c1_q         <= c1_d;
      vld2_q       <= vld2_d;
      sum_q        <= sum_d;
      c2_q         <= c2_d;
      vld3_q       <= vld3_d;
      thr_q        <= thr_d;
      c3_q         <= c3_d;
      cnt_col_q    <= cnt_col_d;
      cnt_row_q    <= cnt_row_d;
      dout_vld_q   <= dout_vld_d;
      dout_q       <= dout_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign dout_vld   = dout_vld_q;
  assign dout       = dout_q;
  assign frame_done = frame_done_q;

endmodule
